uart_rx_core: RTL
=================

# uart_rx_core

Serial receive path of the UART IP: recovers asynchronous frames from the `rx` pin and presents each decoded character with error flags to the control/status register block through a single-entry holding register. It is the counterpart of the transmit path. Line format is run-time configurable: baud from a 16-entry table, 5–8 data bits, optional parity, and 1 or 2 stop bits.

## Interface
- `CLK_FREQ_HZ`, 100_000_000: system clock frequency.
- `BAUD_RATES[16]`, {200, 300, 600, 1200, 1800, 2400, 4800, 9600, 19200, 28800, 38400, 57600, 76800, 115200, 230400, 460800}: baud table indexed by `baud_sel`.

Ports:
- `clk` in 1: system clock. One clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `rx_en` in 1: receiver enable.
- `baud_sel` in 4: baud table index.
- `frame_type` in 2: data bits per frame. 00=5, 01=6, 10=7, 11=8.
- `parity_cfg` in 2: parity mode. 00=none, 01=even, 10=odd, 11=none.
- `stop_type` in 1: stop bits. 0=1 stop, 1=2 stop.
- `rx` in 1: serial line, asynchronous, idle high.
- `rx_ack` in 1: consumer pops the holding register.
- `rx_data` out 8: received character, LSB-aligned; unused upper bits are 0.
- `rx_valid` out 1: holding register full.
- `parity_err` out 1: status for the held character.
- `frame_err` out 1: status for the held character.
- `overrun` out 1: sticky; cleared by `rx_ack`.
- `busy` out 1: high in every state except IDLE.

## Operation
- **Input sync:** `rx` passes through a 2-flop synchronizer; both flops reset to 1. All logic uses the synchronized value `rxs`.
- **Divisor:** `DIV[i] = CLK_FREQ_HZ / BAUD_RATES[i]` (truncating), computed at elaboration. `HALF = DIV >> 1`.
  - Bit counter width is `$clog2(CLK_FREQ_HZ/200 + 1)`.
  - The counter counts down and reloads on every sample.
- **Config latch:** `baud_sel`, `frame_type`, `parity_cfg` and `stop_type` are latched on start detection. Changes during a frame have no effect until the next frame.
- **States:** IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK.
  - **IDLE:** a falling edge on `rxs` (previous 1, current 0) with `rx_en` = 1 moves to START, with the counter loaded to `HALF-1`.
  - **START:** at count 0, sample `rxs`.
    - If `rxs` = 1, it was a false start: go to IDLE and deliver nothing.
    - Otherwise load `DIV-1` and go to DATA.
  - **DATA:** sample once per `DIV` cycles, LSB first, into a shift register, for N bits (5–8). Then go to PARITY if parity is enabled, else STOP1.
  - **PARITY:** sample the parity bit.
    - Even mode: error if XOR(data, bit) = 1.
    - Odd mode: error if XOR(data, bit) = 0.
  - **STOP1:** sample.
    - If `rxs` = 0, set the frame error; the frame is complete; go to BREAK.
    - Else, if `stop_type` = 1, go to STOP2.
    - Else the frame is complete; go to IDLE.
  - **STOP2:** sample.
    - If `rxs` = 0, set the frame error; go to BREAK.
    - Otherwise go to IDLE. The frame is complete either way.
  - **BREAK:** wait for `rxs` = 1, then go to IDLE. This prevents a held-low line from being decoded as a new start.
- **Frame completion:** the holding register loads `rx_data`, `parity_err` and `frame_err`, and sets `rx_valid`.
  - If `rx_valid` is already 1 and `rx_ack` is not asserted in the same cycle, set `overrun` and overwrite with the new frame.
  - Frames with errors are still delivered.
- **Pop:** `rx_ack` while `rx_valid` = 1 clears `rx_valid` and `overrun`.
  - `rx_ack` when `rx_valid` = 0 is ignored.
  - If `rx_ack` arrives in the same cycle as a completion, the new frame is loaded, `rx_valid` stays 1, and no overrun is flagged.
- **Disable:** `rx_en` deasserted mid-frame does not abort the frame; `rx_en` only gates start detection.

## Timing
- **Reset values:**
  - `rx_data` = 0.
  - `rx_valid` = 0, `parity_err` = 0, `frame_err` = 0, `overrun` = 0, `busy` = 0.
  - State = IDLE; synchronizer = 1.
  - Reset mid-frame aborts the frame and delivers nothing.
- **Pin to edge detect:** 2 cycles of synchronizer latency.
- **Sample points:** start is sampled `HALF` cycles after edge detection; each later bit is sampled `DIV` cycles after the previous one.
- **Completion:** `rx_valid` rises 1 cycle after the final stop-bit sample.
- **Back-to-back frames:** the next start edge is detectable from the cycle after the return to IDLE, which is mid-stop-bit. This allows back-to-back frames with no idle gap.
- **`rx_ack` effect:** `rx_valid` falls the cycle after `rx_ack`.

## Test plan
1. **8N1 baseline:** default `CLK_FREQ_HZ`, `baud_sel`=7 (`DIV`=10416), 8N1; send 0xA5 at 9600 baud → one `rx_valid`, `rx_data`=0xA5, no errors.
2. **5-bit, even parity, 2 stop:** `frame_type`=00, `parity_cfg`=01, `stop_type`=1.
   - Send 0x13 with correct parity → `rx_data`=0x13, `parity_err`=0.
   - Resend with the parity bit flipped → `parity_err`=1.
3. **Framing error and break:** 8N1, force stop bit low on 0x3C → `frame_err`=1, `rx_data`=0x3C. Hold `rx` low for 3 bit times → no second frame until `rx` rises and falls again.
4. **Overrun and same-cycle ack:** send 0x11 then 0x22 without `rx_ack` → `overrun`=1, `rx_data`=0x22. Assert `rx_ack` → `rx_valid`=0, `overrun`=0. Ack in the exact completion cycle → no overrun.
5. **Glitch rejection:** 1 µs low glitch on `rx` at 9600 baud → START aborts, no `rx_valid`, `busy` back to 0 within `HALF`+3 cycles.
6. **Fast baud, back-to-back, mid-frame changes:** `baud_sel`=15 (`DIV`=217); stream 0x00, 0xFF, 0x55 back-to-back, changing `baud_sel` mid-frame → all three received correctly at 460800 baud. Assert `rst` mid-frame → all outputs return to reset values, nothing delivered.

Source files
------------

// File: rtl/uart_rx_core.sv
`timescale 1ns/1ps
// uart_rx_core
// Serial receive path of the UART. Recovers asynchronous frames from the rx
// pin and holds each decoded character, with its error flags, in a
// single-entry holding register for the control/status block.
//
// Ports:
//   clk, rst        - system clock, synchronous active-high reset
//   rx_en           - gates start-bit detection only
//   baud_sel        - index into BAUD_RATES (latched at start detection)
//   frame_type      - data bits: 00=5, 01=6, 10=7, 11=8 (latched)
//   parity_cfg      - 00=none, 01=even, 10=odd, 11=none (latched)
//   stop_type       - 0=one stop bit, 1=two stop bits (latched)
//   rx              - asynchronous serial line, idle high
//   rx_ack          - consumer pop of the holding register
//   rx_data         - held character, LSB-aligned, unused upper bits zero
//   rx_valid        - holding register full
//   parity_err      - parity status of the held character
//   frame_err       - stop-bit status of the held character
//   overrun         - sticky: a frame overwrote an unread one; cleared by pop
//   busy            - receiver FSM is not in IDLE
//
// Handshake: rx_valid high means a character is held. rx_ack in a cycle where
// rx_valid is high pops it (rx_valid falls next cycle); rx_ack while rx_valid
// is low is ignored. A completion in the same cycle as a pop loads the new
// frame, keeps rx_valid high and does not flag an overrun.
module uart_rx_core #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATES [16] = '{200, 300, 600, 1200, 1800, 2400, 4800, 9600,
                                    19200, 28800, 38400, 57600, 76800, 115200,
                                    230400, 460800}
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_en,
  input  logic [3:0] baud_sel,
  input  logic [1:0] frame_type,
  input  logic [1:0] parity_cfg,
  input  logic       stop_type,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLK_FREQ_HZ / 200 + 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK
  } state_t;

  // Clock cycles per bit for each table entry; constants after elaboration.
  logic [CNT_W-1:0] div_tab [16];
  for (genvar g = 0; g < 16; g++) begin : g_div
    assign div_tab[g] = CNT_W'(CLK_FREQ_HZ / BAUD_RATES[g]);
  end

  state_t           state, state_n;
  logic             sync1, rxs, rxs_prev;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic             perr_q, perr_n;
  logic [3:0]       cfg_baud;
  logic [1:0]       cfg_frame, cfg_par;
  logic             cfg_stop;
  logic             cfg_load, frame_done, done_ferr;
  logic [CNT_W-1:0] div_cur, half_new;
  logic             tick, par_en, last_bit;

  assign div_cur  = div_tab[cfg_baud];
  // The start countdown is loaded in the same cycle the config is latched,
  // so it must use the live baud_sel rather than the latched copy.
  assign half_new = div_tab[baud_sel] >> 1;
  assign tick     = (cnt == '0);
  assign par_en   = (cfg_par == 2'b01) || (cfg_par == 2'b10);
  assign last_bit = (bit_idx == ({1'b0, cfg_frame} + 3'd4));
  assign busy     = (state != IDLE);

  // 2-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      sync1    <= rx;
      rxs      <= sync1;
      rxs_prev <= rxs;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      perr_q    <= 1'b0;
      cfg_baud  <= '0;
      cfg_frame <= '0;
      cfg_par   <= '0;
      cfg_stop  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      perr_q  <= perr_n;
      if (cfg_load) begin
        cfg_baud  <= baud_sel;
        cfg_frame <= frame_type;
        cfg_par   <= parity_cfg;
        cfg_stop  <= stop_type;
      end
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    perr_n     = perr_q;
    cfg_load   = 1'b0;
    frame_done = 1'b0;
    done_ferr  = 1'b0;
    case (state)
      IDLE: begin
        if (rx_en && rxs_prev && !rxs) begin
          state_n   = START;
          cnt_n     = half_new - 1'b1;
          cfg_load  = 1'b1;
          bit_idx_n = '0;
          shreg_n   = '0;
          perr_n    = 1'b0;
        end
      end
      START: begin
        if (!tick) cnt_n = cnt - 1'b1;
        else if (rxs) state_n = IDLE;  // line back high: glitch, not a start bit
        else begin
          state_n = DATA;
          cnt_n   = div_cur - 1'b1;
        end
      end
      DATA: begin
        if (!tick) cnt_n = cnt - 1'b1;
        else begin
          shreg_n[bit_idx] = rxs;
          cnt_n            = div_cur - 1'b1;
          if (last_bit) state_n = par_en ? PARITY : STOP1;
          else          bit_idx_n = bit_idx + 1'b1;
        end
      end
      PARITY: begin
        if (!tick) cnt_n = cnt - 1'b1;
        else begin
          // Unused upper shreg bits are zero, so they do not disturb the XOR.
          perr_n  = (cfg_par == 2'b01) ? (^shreg ^ rxs) : ~(^shreg ^ rxs);
          cnt_n   = div_cur - 1'b1;
          state_n = STOP1;
        end
      end
      STOP1: begin
        if (!tick) cnt_n = cnt - 1'b1;
        else if (!rxs) begin
          frame_done = 1'b1;
          done_ferr  = 1'b1;
          state_n    = BREAK;
        end else if (cfg_stop) begin
          cnt_n   = div_cur - 1'b1;
          state_n = STOP2;
        end else begin
          frame_done = 1'b1;
          state_n    = IDLE;
        end
      end
      STOP2: begin
        if (!tick) cnt_n = cnt - 1'b1;
        else begin
          frame_done = 1'b1;
          done_ferr  = !rxs;
          state_n    = rxs ? IDLE : BREAK;
        end
      end
      BREAK: begin
        // A line held low must return high before a new start is accepted.
        if (rxs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (frame_done) begin
      rx_data    <= shreg;
      parity_err <= perr_q;
      frame_err  <= done_ferr;
      rx_valid   <= 1'b1;
      if (rx_valid && !rx_ack) overrun <= 1'b1;
      else if (rx_valid)       overrun <= 1'b0;
    end else if (rx_ack && rx_valid) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end
  end

endmodule
